// File: rtl/ex_mul_seq_pkg.sv
// Shared definitions for the EX-stage sequential multiplier: default sizing
// and the ALU control codes used to decode a multiply in EX.
package ex_mul_seq_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_STEP  = 2;

  // ALU control codes shared by the ALU, ALU control and the multiply decode.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_MUL = 3'b100,
    ALU_SUB = 3'b110
  } alu_ctrl_e;

  // Start decode used by EX to drive start_i: a valid instruction whose ALU
  // control selects multiply.
  function automatic logic is_mul_op(input logic valid, input logic [2:0] alu_ctrl);
    logic hit_s;
    if (valid && (alu_ctrl == ALU_MUL)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    return hit_s;
  endfunction

endpackage

// File: rtl/ex_mul_seq_if.sv
// Handshake and operand bundle between the EX stage and the sequential
// multiplier. The pipeline side is the master, the multiplier the slave.
interface ex_mul_seq_if
  import ex_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
);

  logic             start_i;
  logic             flush_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] data_o;

  modport master (
    output start_i,
    output flush_i,
    output data1_i,
    output data2_i,
    input  stall_o,
    input  done_o,
    input  data_o
  );

  modport slave (
    input  start_i,
    input  flush_i,
    input  data1_i,
    input  data2_i,
    output stall_o,
    output done_o,
    output data_o
  );

endinterface

// File: rtl/ex_mul_seq_mul_step.sv
// One radix-2^STEP iteration of the shift-add multiplier:
// sum = acc + mcand * digit, built as STEP shifted-AND partial products.
module mul_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 2
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic [STEP-1:0]  digit,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_s;

  // Accumulate each selected, shifted copy of the multiplicand (mod 2^WIDTH).
  always_comb begin
    sum_s = acc;
    for (int i = 0; i < STEP; i++) begin
      if (digit[i]) begin
        sum_s = sum_s + (mcand << i);
      end else begin
        sum_s = sum_s;
      end
    end
  end

  assign sum = sum_s;

endmodule

// File: rtl/ex_mul_seq.sv
// Iterative multiplier alongside the EX-stage ALU. It latches the operand pair
// when EX holds a multiply, stalls the pipeline while it retires STEP
// multiplier bits per cycle, then pulses done_o with the low WIDTH bits of the
// product on data_o. Latency is fixed regardless of operand values.
module ex_mul_seq
  import ex_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH,
  parameter int unsigned STEP  = MUL_STEP
) (
  input  logic      clk_i,
  input  logic      rst_i,
  ex_mul_seq_if.slave bus
);

  localparam int unsigned N_STEPS = WIDTH / STEP;
  localparam int unsigned CNT_W   = $clog2(N_STEPS + 1);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  if ((WIDTH % STEP) != 0) begin : g_step_check
    $error("ex_mul_seq: WIDTH must be a multiple of STEP");
  end

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] step_sum_s;
  logic             accept_s;
  logic             last_s;
  logic             stall_s;
  logic             done_s;

  // A start is only taken from IDLE; DONE ignores the still-visible instruction.
  assign accept_s = (state_r == ST_IDLE) && bus.start_i && !bus.flush_i;
  assign last_s   = (cnt_r == CNT_ONE);

  mul_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc   (acc_r),
    .mcand (mcand_r),
    .digit (mplier_r[STEP-1:0]),
    .sum   (step_sum_s)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode: flush aborts a running operation, DONE always returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.flush_i) begin
          state_s = ST_IDLE;
        end else if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode: stall covers the accepting cycle and every unflushed RUN cycle.
  always_comb begin
    stall_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: stall_s = accept_s;
      ST_RUN:  stall_s = !bus.flush_i;
      ST_DONE: done_s  = 1'b1;
      default: begin
        stall_s = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // Datapath: operand load on accept, one shift-add step per RUN cycle,
  // result capture on the final step unless the operation is being flushed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      data_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= bus.data1_i;
            mplier_r <= bus.data2_i;
            cnt_r    <= CNT_INIT;
          end
        end
        ST_RUN: begin
          acc_r    <= step_sum_s;
          mcand_r  <= mcand_r << STEP;
          mplier_r <= mplier_r >> STEP;
          cnt_r    <= cnt_r - CNT_ONE;
          if (last_s && !bus.flush_i) begin
            data_r <= step_sum_s;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Reset forces stall low at once, even if EX still presents a multiply.
  assign bus.stall_o = stall_s && !rst_i;
  assign bus.done_o  = done_s;
  assign bus.data_o  = data_r;

endmodule

// File: tb/tb_ex_mul_seq.sv
// Self-checking bench for ex_mul_seq: a table of directed operand pairs with
// hand-computed products, plus hand-written sequences for back-to-back starts,
// flush in RUN and DONE, asynchronous reset mid-operation and operand changes
// while running.
module tb_ex_mul_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ex_mul_seq_if #(.WIDTH(32)) bus ();

  ex_mul_seq #(
    .WIDTH (32),
    .STEP  (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one multiply from the negedge of an IDLE cycle (or, when chained,
  // from the negedge of the previous DONE with start already high and new
  // operands applied). Ends on the DONE negedge if hold, else one cycle later.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input string name, input bit scramble, input bit chained, input bit hold);
    int k;
    bit seen;
    bit stall_ok;
    if (!chained) begin
      bus.data1_i = a;
      bus.data2_i = b;
      bus.flush_i = 1'b0;
      bus.start_i = 1'b1;
      #1;
      check({name, " start-cycle stall"}, 32'(bus.stall_o), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
      check({name, " idle-after-done stall"}, 32'(bus.stall_o), 32'd1);
      check({name, " idle-after-done done"}, 32'(bus.done_o), 32'd0);
    end
    k = 0;
    seen = 1'b0;
    stall_ok = 1'b1;
    while (k < 40 && !seen) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (bus.done_o) begin
        seen = 1'b1;
      end else begin
        if (!bus.stall_o) stall_ok = 1'b0;
        if (scramble) begin
          bus.data1_i = $urandom;
          bus.data2_i = $urandom;
        end
      end
    end
    check({name, " done seen (timeout)"}, 32'(seen), 32'd1);
    check({name, " done latency"}, 32'(k), 32'd17);
    check({name, " stall held in RUN"}, 32'(stall_ok), 32'd1);
    check({name, " stall at done"}, 32'(bus.stall_o), 32'd0);
    check({name, " product"}, bus.data_o, exp);
    if (!hold) begin
      bus.start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({name, " single done pulse"}, 32'(bus.done_o), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          prod: 32'h0000000F};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   prod: 32'h00000001};
    vecs[2] = '{a: 32'h00010000,   b: 32'h00010000,   prod: 32'h00000000};
    vecs[3] = '{a: 32'h80000000,   b: 32'h00000002,   prod: 32'h00000000};
    vecs[4] = '{a: 32'hFFFFFFFF,   b: 32'h00000002,   prod: 32'hFFFFFFFE};
    vecs[5] = '{a: 32'h00010001,   b: 32'h00010001,   prod: 32'h00020001};
    vecs[6] = '{a: 32'h00000000,   b: 32'h12345678,   prod: 32'h00000000};
    vecs[7] = '{a: 32'hDEADBEEF,   b: 32'h00000001,   prod: 32'hDEADBEEF};
    vecs[8] = '{a: 32'h00000007,   b: 32'hFFFFFFFF,   prod: 32'hFFFFFFF9};

    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.data1_i = 32'd0;
    bus.data2_i = 32'd0;
    repeat (3) @(negedge clk);
    check("reset stall", 32'(bus.stall_o), 32'd0);
    check("reset done", 32'(bus.done_o), 32'd0);
    check("reset data", bus.data_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed products, start held for the whole operation.
    for (int i = 0; i < 9; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Start held through DONE, then a back-to-back multiply in the next IDLE cycle.
    run_mul(32'd7, 32'd6, 32'd42, "b2b first", 1'b0, 1'b0, 1'b1);
    bus.data1_i = 32'd9;
    bus.data2_i = 32'd9;
    run_mul(32'd9, 32'd9, 32'h00000051, "b2b second", 1'b0, 1'b1, 1'b0);

    // Flush on the 5th RUN cycle: no done, stall low, previous result kept.
    bus.data1_i = 32'h00001234;
    bus.data2_i = 32'h00000010;
    bus.start_i = 1'b1;
    #1;
    check("flush start stall", 32'(bus.stall_o), 32'd1);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.flush_i = 1'b1;
    #1;
    check("flush-in-run stall", 32'(bus.stall_o), 32'd0);
    check("flush-in-run done", 32'(bus.done_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("flush+start idle stall", 32'(bus.stall_o), 32'd0);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done_o) pulses++;
    end
    check("flush no done", 32'(pulses), 32'd0);
    check("flush data kept", bus.data_o, 32'h00000051);
    run_mul(32'h00001234, 32'h00000010, 32'h00012340, "after flush", 1'b0, 1'b0, 1'b0);

    // Flush in DONE still pulses done; flush+start in IDLE is not accepted.
    run_mul(32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, "flush-done", 1'b0, 1'b0, 1'b1);
    bus.flush_i = 1'b1;
    #1;
    check("flush-in-done done", 32'(bus.done_o), 32'd1);
    check("flush-in-done stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("flush-done idle stall", 32'(bus.stall_o), 32'd0);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("flush-done no restart", 32'(bus.done_o), 32'd0);
    check("flush-done data", bus.data_o, 32'hFFFE0001);

    // Asynchronous reset between edges in the middle of RUN.
    bus.data1_i = 32'd3;
    bus.data2_i = 32'd5;
    bus.start_i = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    check("async rst stall", 32'(bus.stall_o), 32'd0);
    check("async rst done", 32'(bus.done_o), 32'd0);
    check("async rst data", bus.data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post rst done", 32'(bus.done_o), 32'd0);
    run_mul(32'd3, 32'd5, 32'h0000000F, "post rst", 1'b0, 1'b0, 1'b0);

    // Random operands, inputs scrambled during RUN.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_mul(ra, rb, ra * rb, $sformatf("rand%0d", i), 1'b1, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
